gen_sram_clr: RTL and testbench
===============================

GEN_SRAM_CLR -- requirements
Module: gen_sram_clr

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits, any value >=1; byte lanes NB=(DW+7)/8.
REQ-002 SHALL have parameter AW, default 14: address width; depth DP=2**AW.
REQ-003 SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values are 1 and 2, and any other value is an elaboration error.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port data_w, input, DW bits: write data.
REQ-007 SHALL have port addr_w, input, AW bits: write address.
REQ-008 SHALL have port data_wstrb, input, NB bits: per-byte write enable.
REQ-009 SHALL have port en_w, input, 1 bit: write request.
REQ-010 SHALL have port addr_r, input, AW bits: read address.
REQ-011 SHALL have port en_r, input, 1 bit: read request.
REQ-012 SHALL have port data_r, output, DW bits: read data.
REQ-013 SHALL have port valid_r, output, 1 bit: data_r is the result of a read this cycle.
REQ-014 SHALL have port clr, input, 1 bit: clear-all request.
REQ-015 SHALL have port ready, output, 1 bit: the array is initialised and accepting accesses.

Function
REQ-016 SHALL implement the FSM states CLEAR and READY.
REQ-017 In CLEAR, SHALL write zero to address cnt each cycle, with cnt running 0..DP-1, and SHALL enter READY in the cycle after cnt=DP-1 is written.
REQ-018 The clear SHALL take exactly DP cycles; ready=0 throughout CLEAR and 1 in READY.
REQ-019 In READY, clr=1 SHALL reset cnt to 0 and enter CLEAR next cycle; clr during CLEAR SHALL be ignored.
REQ-020 In CLEAR, en_w and en_r SHALL be ignored: no array update and no valid_r.
REQ-021 In READY, en_w=1 SHALL update only the bytes i with data_wstrb[i]=1 at addr_w; bits above DW in the last lane are zero-padded.
REQ-022 In READY, en_r=1 SHALL sample the array at addr_r in that cycle; data_r and valid_r SHALL present the result RD_LAT cycles later.
REQ-023 valid_r SHALL be high for exactly one cycle per accepted read; back-to-back reads SHALL give back-to-back valid_r.
REQ-024 data_r SHALL hold its last value while valid_r=0.
REQ-025 Writes issued after the read's sampling cycle SHALL NOT affect that read's data, even when RD_LAT=2.
REQ-026 clr asserted in READY with reads in flight SHALL let those reads complete with their sampled data.
REQ-027 For the same-cycle read and write collision behaviour, see REQ-031 and REQ-032.

Reset
REQ-028 RST=1 SHALL asynchronously force state=CLEAR, cnt=0, ready=0, valid_r=0, data_r=0, and clear the read pipeline.
REQ-029 After RST deasserts, the block SHALL perform the full DP-cycle clear before ready=1.
REQ-030 RST asserted mid-clear or mid-read SHALL abort the operation and restart per REQ-028; array contents are not reset directly.

Configuration
REQ-031 With macro GEN_SRAM_BYPASS_EN defined, a same-cycle en_r and en_w to the same address SHALL return the new bytes for strobed lanes and the old bytes for the others (write-first).
REQ-032 Without GEN_SRAM_BYPASS_EN, the same collision SHALL return the old contents of all bytes (read-first).

Structure
REQ-033 Package gen_sram_pkg SHALL hold the FSM state typedef (CLEAR, READY) and the RD_LAT legality constants.
REQ-034 The read delay line (data plus valid, 1 or 2 stages, reset-clearable) SHALL be a sub-module, gen_sram_rdpipe.
REQ-035 The array SHALL be a plain register array with no simulation-only random initialisation.

Verification (DW=32, AW=4, DP=16)
REQ-036 Release RST at cycle 0 -> ready=0 for exactly 16 cycles, then 1; read of every address -> 0x00000000.
REQ-037 Write 0xDEADBEEF to addr 3 with strb=0xF, then write 0x11223344 to addr 3 with strb=0x5, then read addr 3 -> 0xDE22BE44, with valid_r RD_LAT cycles after en_r, for RD_LAT=1 and RD_LAT=2.
REQ-038 With addr 5 holding 0xAAAAAAAA, issue in one cycle a write of 0x55555555 with strb=0x3 and a read, both to addr 5 -> 0xAAAA5555 with the bypass macro, 0xAAAAAAAA without it.
REQ-039 With RD_LAT=2, read addr 7 holding 0x1, then write 0x2 to addr 7 next cycle -> data_r=0x1.
REQ-040 Pulse clr in READY with one read in flight -> the read completes, ready=0 for 16 cycles, and all locations read 0.
REQ-041 Assert RST at cnt=8 mid-clear -> valid_r and ready go 0 immediately, and ready returns 16 cycles after release.

Source files
------------

// File: rtl/gen_sram_pkg.sv
`default_nettype none
// gen_sram_pkg: shared FSM state type and read-latency limits for gen_sram_clr.
// Revision: 1.0

package gen_sram_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } sram_state_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 2;

   function automatic bit rd_lat_legal(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/gen_sram_rdpipe.sv
`default_nettype none
// gen_sram_rdpipe: 1- or 2-stage read-data delay line with reset-clearable valid.
// Revision: 1.0

module gen_sram_rdpipe #(
   parameter int DW  = 32,
   parameter int LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data
);

   if (LAT == 1) begin : g_lat1
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
         end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
         end
      end
   end else begin : g_lat2
      logic          mid_valid;
      logic [DW-1:0] mid_data;

      // Data stages load only on valid so the output holds between reads.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mid_valid <= 1'b0;
            mid_data  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
         end else begin
            mid_valid <= in_valid;
            if (in_valid) mid_data <= in_data;
            out_valid <= mid_valid;
            if (mid_valid) out_data <= mid_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/gen_sram_clr.sv
`default_nettype none
// gen_sram_clr: byte-strobed SRAM that zero-fills itself after reset or clr.
// Define GEN_SRAM_BYPASS_EN for write-first same-address collisions (read-first otherwise).

module gen_sram_clr
   import gen_sram_pkg::*;
#(
   parameter int DW     = 32,
   parameter int AW     = 14,
   parameter int RD_LAT = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DW-1:0]         data_w,
   input  logic [AW-1:0]         addr_w,
   input  logic [(DW+7)/8-1:0]   data_wstrb,
   input  logic                  en_w,
   input  logic [AW-1:0]         addr_r,
   input  logic                  en_r,
   output logic [DW-1:0]         data_r,
   output logic                  valid_r,
   input  logic                  clr,
   output logic                  ready
);

   localparam int NB = (DW + 7) / 8;
   localparam int WP = NB * 8;
   localparam int DP = 2 ** AW;
   localparam logic [AW-1:0] CNT_LAST = '1;

   if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
      $error("gen_sram_clr: RD_LAT must be 1 or 2");
   end

   sram_state_t   state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;
   logic [WP-1:0] mem [DP];
   logic [WP-1:0] wpad;
   logic [WP-1:0] rd_word;
   logic          wr_acc;
   logic          rd_acc;

   assign ready  = (state == READY);
   assign wr_acc = ready & en_w;
   assign rd_acc = ready & en_r;
   assign wpad   = WP'(data_w);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         CLEAR: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == CNT_LAST) state_nxt = READY;
         end
         READY: begin
            if (clr) begin
               cnt_nxt   = '0;
               state_nxt = CLEAR;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // Array has no reset; the sweep through CLEAR is what zeroes it.
   always_ff @(posedge CLK) begin
      if (state == CLEAR) begin
         mem[cnt] <= '0;
      end else if (wr_acc) begin
         for (int i = 0; i < NB; i++) begin
            if (data_wstrb[i]) mem[addr_w][8*i +: 8] <= wpad[8*i +: 8];
         end
      end
   end

   always_comb begin
      rd_word = mem[addr_r];
`ifdef GEN_SRAM_BYPASS_EN
      if (wr_acc && (addr_w == addr_r)) begin
         for (int i = 0; i < NB; i++) begin
            if (data_wstrb[i]) rd_word[8*i +: 8] = wpad[8*i +: 8];
         end
      end
`endif
   end

   gen_sram_rdpipe #(
      .DW  (DW),
      .LAT (RD_LAT)
   ) u_rdpipe (
      .clk       (CLK),
      .rst       (RST),
      .in_valid  (rd_acc),
      .in_data   (rd_word[DW-1:0]),
      .out_valid (valid_r),
      .out_data  (data_r)
   );

endmodule

`default_nettype wire

// File: tb/tb_gen_sram_clr.sv
`default_nettype none
// tb_gen_sram_clr: random + directed stimulus on RD_LAT=1 and RD_LAT=2 instances,
// compared every cycle against a behavioural memory/latency model.

module tb_gen_sram_clr;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int DP = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [DW-1:0] data_w = '0;
   logic [AW-1:0] addr_w = '0;
   logic [3:0]    data_wstrb = '0;
   logic          en_w = 1'b0;
   logic [AW-1:0] addr_r = '0;
   logic          en_r = 1'b0;
   logic          clr = 1'b0;

   logic [DW-1:0] data_r1, data_r2;
   logic          valid_r1, valid_r2, ready1, ready2;

   always #5 CLK = ~CLK;

   gen_sram_clr #(.DW(DW), .AW(AW), .RD_LAT(1)) u_lat1 (
      .CLK(CLK), .RST(RST), .data_w(data_w), .addr_w(addr_w), .data_wstrb(data_wstrb),
      .en_w(en_w), .addr_r(addr_r), .en_r(en_r), .data_r(data_r1), .valid_r(valid_r1),
      .clr(clr), .ready(ready1));

   gen_sram_clr #(.DW(DW), .AW(AW), .RD_LAT(2)) u_lat2 (
      .CLK(CLK), .RST(RST), .data_w(data_w), .addr_w(addr_w), .data_wstrb(data_wstrb),
      .en_w(en_w), .addr_r(addr_r), .en_r(en_r), .data_r(data_r2), .valid_r(valid_r2),
      .clr(clr), .ready(ready2));

   // ---------------- behavioural model ----------------
   typedef struct {
      int          due;
      logic [31:0] data;
   } rd_t;

   logic [31:0] model [DP];
   rd_t         q1[$];
   rd_t         q2[$];
   int          clr_left = DP;
   int          cyc = 0;
   logic        ev1 = 1'b0, ev2 = 1'b0;
   logic [31:0] ed1 = '0, ed2 = '0;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         clr_left = DP;
         q1.delete();
         q2.delete();
         ev1 = 1'b0; ev2 = 1'b0;
         ed1 = '0;   ed2 = '0;
         for (int i = 0; i < DP; i++) model[i] = '0;
      end else begin
         logic [31:0] v;
         cyc = cyc + 1;
         if (clr_left > 0) begin
            clr_left = clr_left - 1;
         end else begin
            if (en_r) begin
               v = model[addr_r];
`ifdef GEN_SRAM_BYPASS_EN
               if (en_w && addr_w == addr_r) v = merge(v, data_w, data_wstrb);
`endif
               q1.push_back('{due: cyc, data: v});
               q2.push_back('{due: cyc + 1, data: v});
            end
            if (en_w) model[addr_w] = merge(model[addr_w], data_w, data_wstrb);
            if (clr) begin
               clr_left = DP;
               for (int i = 0; i < DP; i++) model[i] = '0;
            end
         end
         ev1 = 1'b0;
         if (q1.size() > 0 && q1[0].due == cyc) begin
            ev1 = 1'b1; ed1 = q1[0].data; void'(q1.pop_front());
         end
         ev2 = 1'b0;
         if (q2.size() > 0 && q2[0].due == cyc) begin
            ev2 = 1'b1; ed2 = q2[0].data; void'(q2.pop_front());
         end
      end
   end

   // ---------------- compare process ----------------
   int          n_checks = 0;
   int          n_fails  = 0;
   string       lit_name = "";
   logic [31:0] lit_act = '0, lit_exp = '0;
   int          lit_seq = 0;
   int          lit_done = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      chk("ready_l1", {31'b0, ready1}, {31'b0, clr_left == 0});
      chk("ready_l2", {31'b0, ready2}, {31'b0, clr_left == 0});
      chk("valid_l1", {31'b0, valid_r1}, {31'b0, ev1});
      chk("valid_l2", {31'b0, valid_r2}, {31'b0, ev2});
      chk("data_l1", data_r1, ed1);
      chk("data_l2", data_r2, ed2);
      if (lit_seq != lit_done) begin
         chk(lit_name, lit_act, lit_exp);
         lit_done = lit_seq;
      end
   end

   // Last completed read per instance, for the literal checks.
   logic [31:0] cap1_d = '0, cap2_d = '0;
   int          cap1_c = -1, cap2_c = -1;
   always @(negedge CLK) begin
      if (valid_r1) begin cap1_d = data_r1; cap1_c = cyc; end
      if (valid_r2) begin cap2_d = data_r2; cap2_c = cyc; end
   end

   // ---------------- stimulus ----------------
   task automatic post(input string nm, input logic [31:0] a, input logic [31:0] e);
      lit_name = nm;
      lit_act  = a;
      lit_exp  = e;
      lit_seq  = lit_seq + 1;
      @(negedge CLK);
      #1;
   endtask

   task automatic drive(input bit we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input bit re, input logic [3:0] ra,
                        input bit c);
      en_w = we; addr_w = wa; data_w = wd; data_wstrb = ws;
      en_r = re; addr_r = ra; clr = c;
      @(negedge CLK);
      en_w = 1'b0; en_r = 1'b0; clr = 1'b0;
   endtask

   task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      drive(1'b1, a, d, s, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic count_low(input string nm);
      int n;
      n = 0;
      while (ready1 == 1'b0 && n < 100) begin
         n++;
         @(negedge CLK);
      end
      post(nm, n, 16);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (ready1 == 1'b0 && n < 50) begin
         n++;
         @(negedge CLK);
      end
      if (ready1 == 1'b0) post("wait_ready_timeout", 0, 1);
   endtask

   task automatic rd_check(input string nm, input logic [3:0] a, input logic [31:0] exp);
      int ic;
      ic = cyc;
      drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a, 1'b0);
      repeat (3) @(negedge CLK);
      #1;
      post({nm, "_data_l1"}, cap1_d, exp);
      post({nm, "_lat_l1"}, cap1_c - ic, 1);
      post({nm, "_data_l2"}, cap2_d, exp);
      post({nm, "_lat_l2"}, cap2_c - ic, 2);
   endtask

   task automatic read_all();
      for (int a = 0; a < DP; a++) drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'(a), 1'b0);
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      logic [31:0] coll_exp;
      #1 RST = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      count_low("clear_len_reset");
      read_all();

      write(4'd3, 32'hDEADBEEF, 4'hF);
      write(4'd3, 32'h11223344, 4'h5);
      rd_check("strobe_merge", 4'd3, 32'hDE22BE44);

      write(4'd5, 32'hAAAAAAAA, 4'hF);
      drive(1'b1, 4'd5, 32'h55555555, 4'h3, 1'b1, 4'd5, 1'b0);
`ifdef GEN_SRAM_BYPASS_EN
      coll_exp = 32'hAAAA5555;
`else
      coll_exp = 32'hAAAAAAAA;
`endif
      repeat (3) @(negedge CLK);
      #1;
      post("collision_l1", cap1_d, coll_exp);
      post("collision_l2", cap2_d, coll_exp);

      write(4'd7, 32'h1, 4'hF);
      drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd7, 1'b0);
      write(4'd7, 32'h2, 4'hF);
      repeat (3) @(negedge CLK);
      #1;
      post("late_write_l2", cap2_d, 32'h1);
      rd_check("late_write_after", 4'd7, 32'h2);

      for (int i = 0; i < 400; i++) begin
         logic [3:0] wa;
         wa = 4'($urandom_range(0, 15));
         drive($urandom_range(0, 1) == 1, wa, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 1) == 1,
               ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15)),
               $urandom_range(0, 99) == 0);
      end

      wait_ready();
      write(4'd2, 32'h12345678, 4'hF);
      drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2, 1'b1);
      count_low("clear_len_clr");
      post("inflight_l1", cap1_d, 32'h12345678);
      post("inflight_l2", cap2_d, 32'h12345678);
      read_all();
      rd_check("after_clr", 4'd2, 32'h0);

      write(4'd1, 32'hCAFEF00D, 4'hF);
      drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd1, 1'b0);
      #1;
      post("pre_rst_valid_l1", {31'b0, valid_r1}, 32'h1);
      #2 RST = 1'b1;
      #1;
      post("rst_valid_l2", {31'b0, valid_r2}, 32'h0);
      post("rst_data_l1", data_r1, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      count_low("clear_len_rst_read");

      drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b1);
      repeat (8) @(negedge CLK);
      #2 RST = 1'b1;
      #1;
      post("rst_midclear_ready", {31'b0, ready1}, 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      count_low("clear_len_rst_clear");
      read_all();

      repeat (4) @(negedge CLK);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
